sobel_frame_ctrl: RTL and testbench

- Frame-level sequencer for the Sobel/CORDIC edge pipeline (three line buffers, two 3x3 kernels, CORDIC magnitude, 8-bit result).
- Accepts a raster pixel stream with valid/ready and drives the pipeline input and its clock enable. The pipeline advances only on real pixels or flush beats.
- Realigns the pipeline output to pixel coordinates, zeros the one-pixel frame border, and presents results on a valid/ready output with start-of-frame and end-of-line markers.

---
 rtl/sobel_frame_ctrl_if.sv | 14 +
 rtl/sobel_frame_ctrl.sv | 87 ++++++++
 tb/tb_sobel_frame_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// sobel_frame_ctrl_if: pixel stream, pipeline and result stream signals of the Sobel frame sequencer
interface sobel_frame_ctrl_if #(parameter int BITSIZE = 16);
  logic start, in_valid, in_ready, pipe_ce, out_valid, out_sof, out_eol, out_ready, busy, done;
  logic [BITSIZE-1:0] in_data, pipe_sin;
  logic [7:0] pipe_sout, out_data;
  modport master (
    input start, in_valid, in_data, pipe_sout, out_ready,
    output in_ready, pipe_sin, pipe_ce, out_valid, out_data, out_sof, out_eol, busy, done
  );
  modport slave (
    output start, in_valid, in_data, pipe_sout, out_ready,
    input in_ready, pipe_sin, pipe_ce, out_valid, out_data, out_sof, out_eol, busy, done
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencer gating the Sobel pipeline and realigning its output to pixel coordinates
module sobel_frame_ctrl #(
  parameter int BITSIZE = 16,
  parameter int WIDTH   = 256,
  parameter int HEIGHT  = 256,
  parameter int LAT     = 532
) (
  input logic clk,
  input logic rst,
  sobel_frame_ctrl_if.master io
);
  localparam int CW = $clog2(WIDTH*HEIGHT+LAT+1);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [CW-1:0] CE_LAT = CW'(LAT);
  localparam logic [CW-1:0] CE_END = CW'(WIDTH*HEIGHT+LAT);
  localparam logic [XW-1:0] X_END = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_END = YW'(HEIGHT-1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] ce_cnt_q, ce_cnt_d;
  logic [XW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
  logic [YW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
  logic out_valid_q, out_valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [7:0] data_q, data_d;
  logic can_out, accept, ce, capture, last_in, border, idle;
  always_comb begin
    idle = state_q == IDLE;
    can_out = !out_valid_q || io.out_ready;
    accept = state_q == RUN && io.in_valid && can_out;
    ce = accept || (state_q == FLUSH && can_out && ce_cnt_q != CE_END);
    // ce_cnt >= LAT means pipe_sout holds the centre magnitude of pixel ce_cnt-LAT
    capture = ce && ce_cnt_q >= CE_LAT;
    last_in = in_col_q == X_END && in_row_q == Y_END;
    border = out_row_q == '0 || out_row_q == Y_END || out_col_q == '0 || out_col_q == X_END;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = io.start ? RUN : IDLE;
      RUN:     state_d = accept && last_in ? FLUSH : RUN;
      FLUSH:   state_d = ce_cnt_q == CE_END && can_out ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
    ce_cnt_d = idle ? '0 : ce_cnt_q + CW'(ce);
    in_col_d = idle ? '0 : accept ? (in_col_q == X_END ? '0 : in_col_q + 1'b1) : in_col_q;
    in_row_d = idle ? '0 : accept && in_col_q == X_END ? in_row_q + 1'b1 : in_row_q;
    out_col_d = idle ? '0 : capture ? (out_col_q == X_END ? '0 : out_col_q + 1'b1) : out_col_q;
    out_row_d = idle ? '0 : capture && out_col_q == X_END ? out_row_q + 1'b1 : out_row_q;
    data_d = capture ? (border ? 8'h00 : io.pipe_sout) : data_q;
    sof_d = capture ? out_row_q == '0 && out_col_q == '0 : sof_q;
    eol_d = capture ? out_col_q == X_END : eol_q;
    out_valid_d = capture || (out_valid_q && !io.out_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ce_cnt_q <= '0;
      in_col_q <= '0;
      in_row_q <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      out_valid_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ce_cnt_q <= ce_cnt_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      out_valid_q <= out_valid_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
      data_q <= data_d;
    end
  end
  assign io.in_ready = state_q == RUN && can_out;
  assign io.pipe_ce = ce;
  assign io.pipe_sin = state_q == RUN ? io.in_data : '0;
  assign io.out_valid = out_valid_q;
  assign io.out_data = data_q;
  assign io.out_sof = out_valid_q && sof_q;
  assign io.out_eol = out_valid_q && eol_q;
  assign io.busy = state_q == RUN || state_q == FLUSH;
  assign io.done = state_q == DONE;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: directed bench with an 8x4 frame and a 5-deep ce-gated delay line as the pipeline
module tb_sobel_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ff_mode = 1'b0;
  logic [7:0] dl [5];
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] hs_d[$];
  bit hs_s[$];
  bit hs_e[$];
  int hs_c[$];
  int first_rdy, first_ov, ce_n, done_n, done_c, bad_stall, bad_ce;
  sobel_frame_ctrl_if #(.BITSIZE(16)) io ();
  sobel_frame_ctrl #(.BITSIZE(16), .WIDTH(8), .HEIGHT(4), .LAT(5)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (io.pipe_ce) begin
      dl[0] <= io.pipe_sin[7:0];
      for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
    end
  end
  assign io.pipe_sout = ff_mode ? 8'hFF : dl[4];
  function automatic logic [30:0] outs();
    return {io.in_ready, io.pipe_ce, io.out_valid, io.out_sof, io.out_eol, io.busy, io.done, io.pipe_sin, io.out_data};
  endfunction
  function automatic bit border(input int k);
    return k / 8 == 0 || k / 8 == 3 || k % 8 == 0 || k % 8 == 7;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // called and returns at posedge+1; c counts cycles from the one carrying start
  task automatic run_frame(input bit gap, input int stall_at, input int abort_pix, input int extra_start);
    int pix = 0;
    logic [7:0] held = '0;
    hs_d.delete(); hs_s.delete(); hs_e.delete(); hs_c.delete();
    first_rdy = -1; first_ov = -1; ce_n = 0; done_n = 0; done_c = -1; bad_stall = 0; bad_ce = 0;
    for (int c = 0; c < 400; c++) begin
      io.start = c == 0 || c == extra_start;
      io.in_valid = gap ? (c % 2 == 1) : 1'b1;
      io.in_data = 16'(pix);
      io.out_ready = !(stall_at >= 0 && c >= stall_at && c < stall_at + 10);
      @(negedge clk);
      if (io.in_ready && first_rdy < 0) first_rdy = c;
      if (io.out_valid && first_ov < 0) first_ov = c;
      if (c == stall_at) held = io.out_data;
      if (!io.out_ready && (!io.out_valid || io.out_data !== held || io.pipe_ce || io.in_ready)) bad_stall++;
      if (pix < 32 && io.pipe_ce !== (io.in_valid && io.in_ready)) bad_ce++;
      if (io.pipe_ce) ce_n++;
      if (io.done) begin
        done_n++;
        done_c = c;
      end
      if (io.out_valid && io.out_ready) begin
        hs_d.push_back(io.out_data);
        hs_s.push_back(io.out_sof);
        hs_e.push_back(io.out_eol);
        hs_c.push_back(c);
      end
      if (io.in_valid && io.in_ready) pix++;
      if (abort_pix >= 0 && pix == abort_pix) begin
        #2 rst = 1'b0;
        #1 chk("abort_outputs_zero", 64'(outs()), 64'd0);
        io.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      if (done_c >= 0 && c >= done_c + 5) break;
      @(posedge clk);
      #1;
    end
    io.start = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic check_frame(input string name, input bit ff);
    logic [7:0] exp_d;
    chk({name, "_out_count"}, 64'(hs_d.size()), 64'd32);
    for (int k = 0; k < 32 && k < hs_d.size(); k++) begin
      exp_d = border(k) ? 8'h00 : ff ? 8'hFF : 8'(k);
      chk($sformatf("%s_out%0d", name, k), {54'd0, hs_s[k], hs_e[k], hs_d[k]}, {54'd0, k == 0, k % 8 == 7, exp_d});
    end
    chk({name, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({name, "_ce_cycles"}, 64'(ce_n), 64'd37);
    chk({name, "_ce_follows_accept"}, 64'(bad_ce), 64'd0);
    if (hs_c.size() > 0) chk({name, "_done_after_last"}, 64'(done_c), 64'(hs_c[hs_c.size()-1] + 1));
  endtask
  initial begin
    io.start = 1'b0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", 64'(outs()), 64'd0);
    @(posedge clk);
    #1;
    io.start = 1'b1;
    io.in_valid = 1'b1;
    io.in_data = 16'h00AB;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_before_reset", 64'(io.busy), 64'd1);
    chk("valid_before_reset", 64'(io.out_valid), 64'd1);
    #2 rst = 1'b0;
    #1 chk("reset_outputs_zero", 64'(outs()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    io.in_valid = 1'b0;
    io.in_data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle_busy%0d", i), 64'(io.busy), 64'd0);
    end
    @(posedge clk);
    #1;
    run_frame(1'b0, -1, -1, -1);
    chk("cont_first_in_ready", 64'(first_rdy), 64'd1);
    chk("cont_first_out_valid", 64'(first_ov), 64'd7);
    check_frame("cont", 1'b0);
    ff_mode = 1'b1;
    run_frame(1'b0, -1, -1, -1);
    check_frame("mask", 1'b1);
    ff_mode = 1'b0;
    run_frame(1'b1, -1, -1, -1);
    check_frame("gaps", 1'b0);
    run_frame(1'b0, 15, -1, -1);
    chk("stall_frozen", 64'(bad_stall), 64'd0);
    check_frame("stall", 1'b0);
    run_frame(1'b0, -1, 12, -1);
    chk("idle_after_abort", 64'(io.busy), 64'd0);
    run_frame(1'b0, -1, -1, 10);
    check_frame("restart", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
